pulse_selector: RTL and testbench
=================================

Name: pulse_selector

Overview:
- Priority encoder with a registered output stage.
- Samples a vector of single-cycle pulse inputs on every clock edge.
- When any pulse is high, emits a one-cycle `trigger` together with the bit position of the highest-numbered active pulse.
- Sits between event sources (counters, edge detectors) and a consumer that needs one event index per cycle.

Parameters:
- COUNT, 4, number of pulse inputs; legal range 1..256.
- INDEX_WIDTH, 8, width of `index`; must satisfy 2**INDEX_WIDTH >= COUNT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low; asserting it clears all state immediately.
- pulses  input  COUNT  pulse vector; bit i high means event i occurred this cycle.
- index  output  INDEX_WIDTH  position of the highest set bit of `pulses`, registered.
- trigger  output  1  high for one cycle when the sampled `pulses` was non-zero, registered.
- collision  output  1  present only when PULSE_SELECTOR_COLLISION_EN is defined; see Optional Feature.

Behaviour:
- Reset (rst low, asynchronous): trigger=0, index=0, collision=0. Outputs stay at these values while rst is low. The first sample is taken at the first rising edge after rst goes high.
- On each rising edge, with S = `pulses` value at that edge:
  - trigger <= (S != 0).
  - If S != 0: index <= highest i with S[i]=1, zero-extended to INDEX_WIDTH.
  - If S == 0: index holds its previous value. Consumers must qualify `index` with `trigger`.
- Latency: exactly one clock. A pulse present at edge N gives trigger=1 and a valid index from after edge N until edge N+1.
- No combinational path from `pulses` to any output.
- Priority: highest bit wins. Lower simultaneous bits are dropped, not queued; there is no backlog.
- Back-to-back:
  - A pulse held high for k edges gives trigger high for k consecutive cycles, index recomputed each cycle.
  - Alternating non-zero/zero input gives trigger toggling 1/0.
- Pulse width: the input is level-sampled and no edge detection is done. Any bit high at the rising edge counts.
- Reset mid-operation: outputs clear within the reset assertion. A pulse sampled at the same edge as reset release is ignored only if rst is still low at that edge.
- Width rule: COUNT bits map onto indices 0..COUNT-1; the upper index bits are always 0.

Optional Feature:
- Macro: PULSE_SELECTOR_COLLISION_EN.
- Defined:
  - Adds output `collision` (1 bit, registered, same latency as trigger).
  - collision <= 1 when more than one bit of S is set, else 0.
  - collision=1 implies trigger=1. Reset value is 0.
- Not defined: the `collision` port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset hold: rst low for 2 cycles with pulses=4'hF -> trigger=0, index=0 throughout; after release, first edge with 4'hF -> next cycle trigger=1, index=3.
- Exhaustive single-cycle pulses: for each value v in 1..15, drive pulses=v for one edge then 0 -> trigger=1 and index=msb(v) for one cycle (v=1 -> 0, v=6 -> 2, v=9 -> 3), then trigger=0 on the following cycle.
- Idle hold: pulses=4'b0100, then 0 for 3 cycles -> trigger 1,0,0,0; index stays 2 during the idle cycles.
- Sustained input: pulses=4'b0011 held for 3 edges, then 4'b0001 -> trigger high for 4 cycles with index 1,1,1,0.
- Random: 200 cycles of random pulses, each checked one cycle after sampling -> trigger==(pulses!=0); when non-zero, index==msb(pulses).
- Collision (macro defined): pulses=4'b1010 -> collision=1, index=3; pulses=4'b1000 -> collision=0; pulses=0 -> collision=0.

Source files
------------

// File: rtl/pulse_selector.sv
`default_nettype none
// ============================================================================
// Module      : pulse_selector
// Description : Registered priority encoder. Reports the highest-numbered
//               active pulse with a one-cycle trigger. Optional collision
//               flag enabled by defining PULSE_SELECTOR_COLLISION_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_selector #(
    parameter int COUNT       = 4,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COUNT-1:0]       pulses,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   trigger
`ifdef PULSE_SELECTOR_COLLISION_EN
    ,
    output logic                   collision
`endif
);

    logic [INDEX_WIDTH-1:0] w_index;
    logic                   w_any;
    logic [INDEX_WIDTH-1:0] r_index;
    logic                   r_trigger;

    // Ascending scan: the last set bit seen is the highest, so it wins.
    always_comb begin
        w_index = '0;
        w_any   = 1'b0;
        for (int i = 0; i < COUNT; i++) begin
            if (pulses[i]) begin
                w_any   = 1'b1;
                w_index = INDEX_WIDTH'(i);
            end
        end
    end

    // Index holds while idle; consumers qualify it with trigger.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_index   <= '0;
            r_trigger <= 1'b0;
        end else begin
            r_trigger <= w_any;
            if (w_any) begin
                r_index <= w_index;
            end
        end
    end

    assign index   = r_index;
    assign trigger = r_trigger;

`ifdef PULSE_SELECTOR_COLLISION_EN
    logic w_multi;
    logic r_collision;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = (pulses & (pulses - COUNT'(1))) != '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_multi;
        end
    end

    assign collision = r_collision;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_selector.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_selector
// Description : Directed and random self-checking bench for pulse_selector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_selector;

    logic       clk;
    logic       rst;
    logic [3:0] pulses;
    logic [7:0] index;
    logic       trigger;
`ifdef PULSE_SELECTOR_COLLISION_EN
    logic       collision;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    // Hand-computed highest set bit for 0..15.
    int msb_tab [16] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};

    pulse_selector #(
        .COUNT       (4),
        .INDEX_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pulses    (pulses),
        .index     (index),
        .trigger   (trigger)
`ifdef PULSE_SELECTOR_COLLISION_EN
        ,
        .collision (collision)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are then stable for checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int v;
        rst    = 1'b0;
        pulses = 4'hF;

        // Reset hold with all pulses active.
        repeat (2) begin
            tick();
            check("rst_trig", 32'(trigger), 32'd0);
            check("rst_idx",  32'(index),   32'd0);
`ifdef PULSE_SELECTOR_COLLISION_EN
            check("rst_coll", 32'(collision), 32'd0);
`endif
        end
        rst = 1'b1;
        tick();
        check("rel_trig", 32'(trigger), 32'd1);
        check("rel_idx",  32'(index),   32'd3);

        // Every single-cycle pattern, each followed by an idle cycle.
        for (int k = 1; k < 16; k++) begin
            pulses = 4'(k);
            tick();
            check("one_trig", 32'(trigger), 32'd1);
            check("one_idx",  32'(index),   32'(msb_tab[k]));
            pulses = 4'h0;
            tick();
            check("one_idle", 32'(trigger), 32'd0);
        end

        // Idle hold keeps the last index.
        pulses = 4'b0100;
        tick();
        check("hold_trig", 32'(trigger), 32'd1);
        check("hold_idx",  32'(index),   32'd2);
        pulses = 4'h0;
        repeat (3) begin
            tick();
            check("hold_trig0", 32'(trigger), 32'd0);
            check("hold_idx0",  32'(index),   32'd2);
        end

        // Sustained input.
        pulses = 4'b0011;
        repeat (3) begin
            tick();
            check("sus_trig", 32'(trigger), 32'd1);
            check("sus_idx",  32'(index),   32'd1);
        end
        pulses = 4'b0001;
        tick();
        check("sus_trig", 32'(trigger), 32'd1);
        check("sus_idx",  32'(index),   32'd0);
        pulses = 4'h0;
        tick();
        check("sus_end", 32'(trigger), 32'd0);

        // Asynchronous reset mid-operation clears without a clock edge.
        pulses = 4'b1000;
        tick();
        check("mid_trig", 32'(trigger), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_trig", 32'(trigger), 32'd0);
        check("mid_rst_idx",  32'(index),   32'd0);
        tick();
        check("mid_hold_trig", 32'(trigger), 32'd0);
        rst    = 1'b1;
        pulses = 4'h0;
        tick();

`ifdef PULSE_SELECTOR_COLLISION_EN
        pulses = 4'b1010;
        tick();
        check("col_a",   32'(collision), 32'd1);
        check("col_idx", 32'(index),     32'd3);
        pulses = 4'b1000;
        tick();
        check("col_b",   32'(collision), 32'd0);
        pulses = 4'b0000;
        tick();
        check("col_c",   32'(collision), 32'd0);
`endif

        // Random patterns against the lookup table.
        for (int n = 0; n < 200; n++) begin
            v      = int'($urandom_range(0, 15));
            pulses = 4'(v);
            tick();
            check("rnd_trig", 32'(trigger), (v != 0) ? 32'd1 : 32'd0);
            if (v != 0) begin
                check("rnd_idx", 32'(index), 32'(msb_tab[v]));
            end
`ifdef PULSE_SELECTOR_COLLISION_EN
            check("rnd_coll", 32'(collision), ($countones(4'(v)) > 1) ? 32'd1 : 32'd0);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
